// File: rtl/serv_lsu_pkg.sv
// Shared definitions for the serial load/store sequencer: FSM state
// encoding, access size codes and the byte-lane select helper.
package serv_lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_BUS   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // Byte lanes touched by an access of the given size at the given offset.
   // Size 11 falls into the word case.
   function automatic logic [3:0] lane_sel(input logic [1:0] size,
                                           input logic [1:0] lsb);
      logic [3:0] sel;
      case (size)
         SZ_B:    sel = 4'b0001 << lsb;
         SZ_H:    sel = lsb[1] ? 4'b1100 : 4'b0011;
         default: sel = 4'b1111;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/serv_lsu_align.sv
// Load data alignment: shifts the addressed bytes of the bus word down to
// bit 0 and sign- or zero-extends bytes and halfwords to 32 bits.
module serv_lsu_align
   import serv_lsu_pkg::*;
(
   input  logic [31:0] rdt,
   input  logic [1:0]  lsb,
   input  logic [1:0]  size,
   input  logic        sgn,
   output logic [31:0] data
);

   logic [31:0] r;

   // Align to the byte offset, then extend according to size and signedness.
   always_comb begin
      r = rdt >> {lsb, 3'b000};
      case (size)
         SZ_B:    data = {{24{sgn & r[7]}}, r[7:0]};
         SZ_H:    data = {{16{sgn & r[15]}}, r[15:0]};
         default: data = r;
      endcase
   end

endmodule

// File: rtl/serv_lsu_seq.sv
// Serial load/store sequencer. Collects rs2 store data W bits per strobe,
// issues one data-bus cycle, and returns aligned/extended load data W bits
// per strobe. Misaligned requests are rejected without touching the bus.
//
// Bus handshake: o_dbus_cyc is raised on entry to BUS and held, together
// with adr/sel/we/dat, until the first clock edge where i_dbus_ack is seen
// while cyc is already high; cyc drops on that same edge. An ack while cyc
// is low is ignored.
module serv_lsu_seq
   import serv_lsu_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1,
   parameter int LB = $clog2(BITS_PER_CYCLE)
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   input  logic                      i_we,
   input  logic [1:0]                i_size,
   input  logic                      i_signed,
   input  logic [31:0]               i_adr,
   input  logic [1:0]                i_lsb,
   input  logic                      i_en,
   input  logic [BITS_PER_CYCLE-1:0] i_rs2,
   output logic [BITS_PER_CYCLE-1:0] o_rd,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_misalign,
   output logic                      o_dbus_cyc,
   output logic                      o_dbus_we,
   output logic [31:0]               o_dbus_adr,
   output logic [3:0]                o_dbus_sel,
   output logic [31:0]               o_dbus_dat,
   input  logic [31:0]               i_dbus_rdt,
   input  logic                      i_dbus_ack
);

   localparam int W  = BITS_PER_CYCLE;
   localparam int CW = 5 - LB;

   state_t        state_q, state_d;
   logic          we_q, sgn_q;
   logic [1:0]    size_q, lsb_q;
   logic [31:0]   adr_q;
   logic [31:0]   shreg;
   logic [CW-1:0] cnt_q;
   logic          cyc_q, done_q, mis_q;
   logic [31:0]   load_word;

   logic start_ok, misaligned, cnt_last, ack_ok;

   assign start_ok   = i_start && (state_q == ST_IDLE);
   assign misaligned = ((i_size == SZ_H) && i_lsb[0]) ||
                       (i_size[1] && (i_lsb != 2'b00));
   assign cnt_last   = (cnt_q == {CW{1'b1}});
   assign ack_ok     = cyc_q && i_dbus_ack;

   serv_lsu_align u_align (
      .rdt  (i_dbus_rdt),
      .lsb  (lsb_q),
      .size (size_q),
      .sgn  (sgn_q),
      .data (load_word)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start && !misaligned)
               state_d = i_we ? ST_FILL : ST_BUS;
         end
         ST_FILL: begin
            if (i_en && cnt_last) state_d = ST_BUS;
         end
         ST_BUS: begin
            if (ack_ok) state_d = we_q ? ST_IDLE : ST_DRAIN;
         end
         ST_DRAIN: begin
            if (i_en && cnt_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request latches, step counter, shift register, bus request and pulses.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         we_q   <= 1'b0;
         sgn_q  <= 1'b0;
         size_q <= 2'b00;
         lsb_q  <= 2'b00;
         adr_q  <= 32'h0;
         shreg  <= 32'h0;
         cnt_q  <= '0;
         cyc_q  <= 1'b0;
         done_q <= 1'b0;
         mis_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         mis_q  <= 1'b0;
         cyc_q  <= (state_d == ST_BUS);
         if (start_ok) begin
            we_q   <= i_we;
            sgn_q  <= i_signed;
            size_q <= i_size;
            lsb_q  <= i_lsb;
            adr_q  <= i_adr;
            cnt_q  <= '0;
            mis_q  <= misaligned;
         end
         case (state_q)
            ST_FILL: begin
               if (i_en) begin
                  shreg <= {i_rs2, shreg[31:W]};
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_BUS: begin
               if (ack_ok) begin
                  if (we_q) done_q <= 1'b1;
                  else      shreg  <= load_word;
               end
            end
            ST_DRAIN: begin
               if (i_en) begin
                  shreg <= {{W{1'b0}}, shreg[31:W]};
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_last) done_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs derived from state and latched request fields.
   always_comb begin
      o_busy     = (state_q != ST_IDLE);
      o_rd       = ((state_q == ST_DRAIN) && i_en) ? shreg[W-1:0] : '0;
      o_dbus_sel = (state_q == ST_BUS) ? lane_sel(size_q, lsb_q) : 4'b0000;
      case (size_q)
         SZ_B:    o_dbus_dat = {4{shreg[7:0]}};
         SZ_H:    o_dbus_dat = {2{shreg[15:0]}};
         default: o_dbus_dat = shreg;
      endcase
   end

   assign o_done     = done_q;
   assign o_misalign = mis_q;
   assign o_dbus_cyc = cyc_q;
   assign o_dbus_we  = we_q;
   assign o_dbus_adr = adr_q;

endmodule

// File: tb/tb_serv_lsu_seq.sv
// Directed bench for serv_lsu_seq with W=1, W=4 and W=8 instances sharing
// clock, reset and the bus/request fields; each has its own start/strobe.
module tb_serv_lsu_seq;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // shared inputs
   logic        we, sgn, ack;
   logic [1:0]  size, lsb;
   logic [31:0] adr, rdt;

   // per-instance signals
   logic        start1, start4, start8;
   logic        en1, en4, en8;
   logic [0:0]  rs2_1, rd1;
   logic [3:0]  rs2_4, rd4;
   logic [7:0]  rs2_8, rd8;
   logic        busy1, busy4, busy8, done1, done4, done8, mis1, mis4, mis8;
   logic        cyc1, cyc4, cyc8, dwe1, dwe4, dwe8;
   logic [31:0] dadr1, dadr4, dadr8, ddat1, ddat4, ddat8;
   logic [3:0]  dsel1, dsel4, dsel8;

   serv_lsu_seq #(.BITS_PER_CYCLE(1)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_we(we), .i_size(size),
      .i_signed(sgn), .i_adr(adr), .i_lsb(lsb), .i_en(en1), .i_rs2(rs2_1),
      .o_rd(rd1), .o_busy(busy1), .o_done(done1), .o_misalign(mis1),
      .o_dbus_cyc(cyc1), .o_dbus_we(dwe1), .o_dbus_adr(dadr1), .o_dbus_sel(dsel1),
      .o_dbus_dat(ddat1), .i_dbus_rdt(rdt), .i_dbus_ack(ack));

   serv_lsu_seq #(.BITS_PER_CYCLE(4)) u4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_we(we), .i_size(size),
      .i_signed(sgn), .i_adr(adr), .i_lsb(lsb), .i_en(en4), .i_rs2(rs2_4),
      .o_rd(rd4), .o_busy(busy4), .o_done(done4), .o_misalign(mis4),
      .o_dbus_cyc(cyc4), .o_dbus_we(dwe4), .o_dbus_adr(dadr4), .o_dbus_sel(dsel4),
      .o_dbus_dat(ddat4), .i_dbus_rdt(rdt), .i_dbus_ack(ack));

   serv_lsu_seq #(.BITS_PER_CYCLE(8)) u8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_we(we), .i_size(size),
      .i_signed(sgn), .i_adr(adr), .i_lsb(lsb), .i_en(en8), .i_rs2(rs2_8),
      .o_rd(rd8), .o_busy(busy8), .o_done(done8), .o_misalign(mis8),
      .o_dbus_cyc(cyc8), .o_dbus_we(dwe8), .o_dbus_adr(dadr8), .o_dbus_sel(dsel8),
      .o_dbus_dat(ddat8), .i_dbus_rdt(rdt), .i_dbus_ack(ack));

   // view of the instance currently under test
   int          cur;
   logic        m_busy, m_done, m_mis, m_cyc, m_we;
   logic [7:0]  m_rd;
   logic [3:0]  m_sel;
   logic [31:0] m_adr, m_dat;

   always_comb begin
      m_busy = busy1; m_done = done1; m_mis = mis1; m_cyc = cyc1; m_we = dwe1;
      m_rd = {7'b0, rd1}; m_sel = dsel1; m_adr = dadr1; m_dat = ddat1;
      case (cur)
         4: begin
            m_busy = busy4; m_done = done4; m_mis = mis4; m_cyc = cyc4; m_we = dwe4;
            m_rd = {4'b0, rd4}; m_sel = dsel4; m_adr = dadr4; m_dat = ddat4;
         end
         8: begin
            m_busy = busy8; m_done = done8; m_mis = mis8; m_cyc = cyc8; m_we = dwe8;
            m_rd = rd8; m_sel = dsel8; m_adr = dadr8; m_dat = ddat8;
         end
         default: ;
      endcase
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input logic v);
      case (cur)
         4:       start4 = v;
         8:       start8 = v;
         default: start1 = v;
      endcase
   endtask

   task automatic start_acc(input logic w, input logic [1:0] sz, input logic s,
                            input logic [31:0] a, input logic [1:0] l);
      we = w; size = sz; sgn = s; adr = a; lsb = l;
      set_start(1'b1);
      step();
      set_start(1'b0);
   endtask

   // One i_en strobe; returns o_rd as seen during the strobe cycle.
   task automatic strobe(input logic [7:0] d, output logic [7:0] rd);
      case (cur)
         4:       begin en4 = 1'b1; rs2_4 = d[3:0]; end
         8:       begin en8 = 1'b1; rs2_8 = d; end
         default: begin en1 = 1'b1; rs2_1 = d[0:0]; end
      endcase
      #1;
      rd = m_rd;
      step();
      en1 = 1'b0; en4 = 1'b0; en8 = 1'b0;
   endtask

   task automatic fill(input logic [31:0] d);
      logic [7:0]  c;
      logic [31:0] t;
      for (int i = 0; i < 32 / cur; i++) begin
         t = d >> (i * cur);
         strobe(t[7:0], c);
      end
   endtask

   task automatic drain(output logic [31:0] val);
      logic [7:0] c;
      val = 32'h0;
      for (int i = 0; i < 32 / cur; i++) begin
         strobe(8'h00, c);
         val = val | ({24'h0, c} << (i * cur));
      end
   endtask

   task automatic bus_ack(input logic [31:0] data);
      rdt = data;
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] v;
   logic [7:0]  b;

   initial begin
      cur = 1;
      rst_n = 1'b0; we = 0; sgn = 0; ack = 0; size = 0; lsb = 0; adr = 0; rdt = 0;
      start1 = 0; start4 = 0; start8 = 0; en1 = 0; en4 = 0; en8 = 0;
      rs2_1 = 0; rs2_4 = 0; rs2_8 = 0;
      step(); step();

      // reset values
      check("rst_busy", {31'b0, m_busy}, 0);
      check("rst_cyc",  {31'b0, m_cyc}, 0);
      check("rst_done", {31'b0, m_done}, 0);
      check("rst_we",   {31'b0, m_we}, 0);
      check("rst_adr",  m_adr, 0);
      check("rst_sel",  {28'b0, m_sel}, 0);
      check("rst_dat",  m_dat, 0);
      rst_n = 1'b1;
      step();

      // W=1 store word
      cur = 1;
      start_acc(1'b1, 2'b10, 1'b0, 32'h100, 2'd0);
      check("sw_busy", {31'b0, m_busy}, 1);
      check("sw_cyc_fill", {31'b0, m_cyc}, 0);
      fill(32'hDEADBEEF);
      check("sw_cyc", {31'b0, m_cyc}, 1);
      check("sw_we",  {31'b0, m_we}, 1);
      check("sw_adr", m_adr, 32'h100);
      check("sw_sel", {28'b0, m_sel}, 32'hF);
      check("sw_dat", m_dat, 32'hDEADBEEF);
      strobe(8'hFF, b);                        // strobe in BUS: no effect
      step();
      check("sw_cyc_hold", {31'b0, m_cyc}, 1);
      check("sw_dat_hold", m_dat, 32'hDEADBEEF);
      check("sw_done_early", {31'b0, m_done}, 0);
      bus_ack(32'h0);
      check("sw_done", {31'b0, m_done}, 1);
      check("sw_cyc_off", {31'b0, m_cyc}, 0);
      step();
      check("sw_done_pulse", {31'b0, m_done}, 0);
      check("sw_idle", {31'b0, m_busy}, 0);

      // W=1 load byte signed / unsigned at lsb=2
      start_acc(1'b0, 2'b00, 1'b1, 32'h200, 2'd2);
      check("lb_cyc", {31'b0, m_cyc}, 1);
      check("lb_sel", {28'b0, m_sel}, 32'h4);
      bus_ack(32'h00800000);
      check("lb_cyc_off", {31'b0, m_cyc}, 0);
      drain(v);
      check("lb_signed", v, 32'hFFFFFF80);
      check("lb_done", {31'b0, m_done}, 1);
      step();
      start_acc(1'b0, 2'b00, 1'b0, 32'h200, 2'd2);
      bus_ack(32'h00800000);
      drain(v);
      check("lbu", v, 32'h00000080);
      step();

      // W=4 store half at lsb=2
      cur = 4;
      start_acc(1'b1, 2'b01, 1'b0, 32'h340, 2'd2);
      fill(32'h0000A5C3);
      check("sh_cyc", {31'b0, m_cyc}, 1);
      check("sh_sel", {28'b0, m_sel}, 32'hC);
      check("sh_dat", m_dat, 32'hA5C3A5C3);
      check("sh_adr", m_adr, 32'h340);
      bus_ack(32'h0);
      check("sh_done", {31'b0, m_done}, 1);
      step();

      // misaligned word load
      cur = 1;
      start_acc(1'b0, 2'b10, 1'b0, 32'h400, 2'd1);
      check("mis_pulse", {31'b0, m_mis}, 1);
      check("mis_busy", {31'b0, m_busy}, 0);
      check("mis_cyc", {31'b0, m_cyc}, 0);
      step();
      check("mis_clear", {31'b0, m_mis}, 0);
      check("mis_cyc2", {31'b0, m_cyc}, 0);

      // misaligned half (lsb[0]=1) also rejected
      start_acc(1'b0, 2'b01, 1'b0, 32'h400, 2'd3);
      check("mis_half", {31'b0, m_mis}, 1);
      step();

      // ack held through cyc rise plus a second start while busy
      rdt = 32'hCAFEF00D;
      ack = 1'b1;
      start_acc(1'b0, 2'b10, 1'b0, 32'h500, 2'd0);
      check("ar_cyc", {31'b0, m_cyc}, 1);
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      ack = 1'b0;
      check("ar_cyc_off", {31'b0, m_cyc}, 0);
      check("ar_busy", {31'b0, m_busy}, 1);
      drain(v);
      check("ar_data", v, 32'hCAFEF00D);
      step();
      check("ar_idle", {31'b0, m_busy}, 0);
      check("ar_no_second", {31'b0, m_cyc}, 0);

      // reset during BUS, ack afterwards
      start_acc(1'b0, 2'b10, 1'b0, 32'h600, 2'd0);
      check("rb_cyc", {31'b0, m_cyc}, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      bus_ack(32'h11111111);
      check("rb_cyc_off", {31'b0, m_cyc}, 0);
      check("rb_done", {31'b0, m_done}, 0);
      check("rb_busy", {31'b0, m_busy}, 0);
      step();
      check("rb_done2", {31'b0, m_done}, 0);

      // W=8 load word
      cur = 8;
      start_acc(1'b0, 2'b10, 1'b0, 32'h700, 2'd0);
      bus_ack(32'h12345678);
      check("lw8_rd_idle", {24'b0, m_rd}, 0);
      strobe(8'h00, b); check("lw8_b0", {24'b0, b}, 32'h78);
      strobe(8'h00, b); check("lw8_b1", {24'b0, b}, 32'h56);
      strobe(8'h00, b); check("lw8_b2", {24'b0, b}, 32'h34);
      strobe(8'h00, b); check("lw8_b3", {24'b0, b}, 32'h12);
      check("lw8_done", {31'b0, m_done}, 1);
      step();
      check("lw8_idle", {31'b0, m_busy}, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
